// File: rtl/sa_input_feeder.sv
// Input feeder for a 4x4 weight-stationary systolic array: weight-load sequencing, diagonal activation skew, drain and done.
// Optional FEEDER_STALL_CNT_EN adds a stall_cnt output counting STREAM cycles starved of activations.
module sa_input_feeder #(
  parameter int bit_width = 8,
  parameter int size      = 4,
  parameter int cnt_width = 16,
  parameter int drain_len = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [cnt_width-1:0]      num_vec,
  input  logic                      wt_valid,
  output logic                      wt_ready,
  input  logic [bit_width*size-1:0] wt_data,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [bit_width*size-1:0] act_data,
  output logic                      control,
  output logic [bit_width*size-1:0] wt_arr,
  output logic [bit_width*size-1:0] data_arr,
  output logic                      busy,
  output logic                      done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [cnt_width-1:0]      stall_cnt
`endif
);

  localparam int row_w = $clog2(size + 1);
  localparam int dr_w  = $clog2(drain_len + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_WT = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [cnt_width-1:0] num_vec_q;
  logic [cnt_width-1:0] vec_cnt;
  logic [row_w-1:0]     row_cnt;
  logic [dr_w-1:0]      drain_cnt;
  logic                 wt_hs;
  logic                 act_hs;
  logic                 advance;

  assign wt_ready  = (state == S_LOAD_WT);
  assign act_ready = (state == S_STREAM) && (vec_cnt < num_vec_q);
  assign busy      = (state == S_LOAD_WT) || (state == S_STREAM) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign wt_hs     = wt_valid && wt_ready;
  assign act_hs    = act_valid && act_ready;
  assign advance   = (state == S_STREAM) || (state == S_DRAIN);

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_LOAD_WT;
      S_LOAD_WT: begin
        if (wt_hs && row_cnt == row_w'(size - 1))
          next_state = (num_vec_q == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM:  if (act_hs && (vec_cnt + cnt_width'(1)) == num_vec_q) next_state = S_DRAIN;
      S_DRAIN:   if (drain_cnt == dr_w'(drain_len - 1)) next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      num_vec_q <= '0;
      vec_cnt   <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      control   <= 1'b0;
      wt_arr    <= '0;
    end else begin
      state   <= next_state;
      control <= wt_hs;
      if (wt_hs) begin
        wt_arr  <= wt_data;
        row_cnt <= row_cnt + row_w'(1);
      end
      if (state == S_IDLE && start) begin
        num_vec_q <= num_vec;
        vec_cnt   <= '0;
        row_cnt   <= '0;
        drain_cnt <= '0;
      end
      if (act_hs)
        vec_cnt <= vec_cnt + cnt_width'(1);
      if (state == S_DRAIN)
        drain_cnt <= drain_cnt + dr_w'(1);
    end
  end

  // Lane k is a (k+1)-deep shift line; bubbles and drain push zeros so the diagonal stays aligned.
  for (genvar k = 0; k < size; k++) begin : g_lane
    logic [bit_width-1:0] pipe [k+1];

    // NOTE: the skew line is a handful of flops, not a RAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= k; j++) pipe[j] <= '0;
      end else if (!advance) begin
        for (int j = 0; j <= k; j++) pipe[j] <= '0;
      end else begin
        pipe[0] <= act_hs ? act_data[k*bit_width +: bit_width] : '0;
        for (int j = 1; j <= k; j++) pipe[j] <= pipe[j-1];
      end
    end

    assign data_arr[k*bit_width +: bit_width] = pipe[k];
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == S_IDLE && start)
      stall_cnt <= '0;
    else if (act_ready && !act_valid && stall_cnt != '1)
      stall_cnt <= stall_cnt + cnt_width'(1);
  end
`endif

endmodule

// File: tb/tb_sa_input_feeder.sv
// Directed bench for sa_input_feeder: reset/abort, weight load, skew timing, bubbles and empty jobs.
module tb_sa_input_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic        wt_valid = 1'b0;
  logic        wt_ready;
  logic [31:0] wt_data = '0;
  logic        act_valid = 1'b0;
  logic        act_ready;
  logic [31:0] act_data = '0;
  logic        control;
  logic [31:0] wt_arr;
  logic [31:0] data_arr;
  logic        busy;
  logic        done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] rows [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

  sa_input_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .control(control), .wt_arr(wt_arr), .data_arr(data_arr),
    .busy(busy), .done(done)
`ifdef FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Outputs are observed 1 time unit after the rising edge; inputs change right after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] n);
    start = 1'b1;
    num_vec = n;
    tick();
    start = 1'b0;
    num_vec = '0;
  endtask

  // Four weight rows with wt_valid held high; returns in the cycle after the 4th handshake.
  task automatic load_held();
    for (int i = 0; i < 4; i++) begin
      wt_valid = 1'b1;
      wt_data = rows[i];
      tick();
      checks++; if (control !== 1'b1) begin errors++; $display("FAIL wt_ctrl[%0d]: got %b want 1", i, control); end
      checks++; if (wt_arr !== rows[i]) begin errors++; $display("FAIL wt_arr[%0d]: got %h want %h", i, wt_arr, rows[i]); end
    end
    wt_valid = 1'b0;
    wt_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if ({control, busy, done, wt_ready, act_ready} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want 00000", {control, busy, done, wt_ready, act_ready}); end
    checks++; if (wt_arr !== 32'h0) begin errors++; $display("FAIL reset_wt_arr: got %h want 0", wt_arr); end
    checks++; if (data_arr !== 32'h0) begin errors++; $display("FAIL reset_data_arr: got %h want 0", data_arr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    start_job(16'd5);
    load_held();
    act_valid = 1'b1; act_data = 32'hA4A3A2A1;
    tick();
    act_data = 32'hB4B3B2B1;
    tick();
    act_valid = 1'b0; act_data = '0;
    checks++; if (data_arr !== 32'h0000A2B1) begin errors++; $display("FAIL abort_pre_data: got %h want 0000a2b1", data_arr); end
    checks++; if (busy !== 1'b1 || act_ready !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b%b want 11", busy, act_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({control, busy, done, wt_ready, act_ready} !== 5'b0) begin errors++; $display("FAIL abort_ctl: got %b want 00000", {control, busy, done, wt_ready, act_ready}); end
    checks++; if (data_arr !== 32'h0 || wt_arr !== 32'h0) begin errors++; $display("FAIL abort_data: got %h/%h want 0/0", data_arr, wt_arr); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done[%0d]: got done=%b busy=%b want 0 0", i, done, busy); end
    end
  endtask

  task automatic test_weight_and_skew();
    logic [31:0] exp_data [11] = '{32'h0, 32'h00000011, 32'h00002200, 32'h00330000, 32'h44000000,
                                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    start_job(16'd1);
    checks++; if (wt_ready !== 1'b1 || busy !== 1'b1 || control !== 1'b0) begin errors++; $display("FAIL load_entry: got rdy=%b busy=%b ctl=%b want 1 1 0", wt_ready, busy, control); end
    checks++; if (data_arr !== 32'h0) begin errors++; $display("FAIL load_data_zero: got %h want 0", data_arr); end
    load_held();
    checks++; if (wt_ready !== 1'b0 || act_ready !== 1'b1) begin errors++; $display("FAIL load_exit: got wt_rdy=%b act_rdy=%b want 0 1", wt_ready, act_ready); end
    act_valid = 1'b1; act_data = 32'h44332211;
    for (int j = 1; j <= 10; j++) begin
      tick();
      act_valid = 1'b0; act_data = '0;
      checks++; if (data_arr !== exp_data[j]) begin errors++; $display("FAIL skew_data[t+%0d]: got %h want %h", j, data_arr, exp_data[j]); end
      checks++; if (done !== (j == 9)) begin errors++; $display("FAIL skew_done[t+%0d]: got %b want %b", j, done, (j == 9)); end
      if (j == 1) begin
        checks++; if (act_ready !== 1'b0 || control !== 1'b0) begin errors++; $display("FAIL skew_ready: got rdy=%b ctl=%b want 0 0", act_ready, control); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL skew_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_wt_toggle();
    int ones = 0;
    start_job(16'd0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (control !== (i % 2 == 1)) begin errors++; $display("FAIL toggle_ctl[%0d]: got %b want %b", i, control, (i % 2 == 1)); end
      if (control === 1'b1) ones++;
      wt_valid = (i % 2 == 0);
      wt_data = wt_valid ? rows[i/2] : 32'hDEADBEEF;
      tick();
    end
    wt_valid = 1'b0; wt_data = '0;
    if (control === 1'b1) ones++;
    checks++; if (wt_arr !== rows[3] || wt_ready !== 1'b0) begin errors++; $display("FAIL toggle_last: got %h rdy=%b want %h 0", wt_arr, wt_ready, rows[3]); end
    tick();
    if (control === 1'b1) ones++;
    checks++; if (ones != 4) begin errors++; $display("FAIL toggle_count: got %0d want 4", ones); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL toggle_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_bubble();
    logic [31:0] exp_data [14] = '{32'h0, 32'h00000011, 32'h00001221, 32'h00132200, 32'h14230031,
                                   32'h24003200, 32'h00330000, 32'h34000000, 32'h0, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0};
    logic        vld [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] vec [4] = '{32'h14131211, 32'h24232221, 32'hFFFFFFFF, 32'h34333231};
    start_job(16'd3);
    load_held();
    for (int off = 0; off < 14; off++) begin
      checks++; if (data_arr !== exp_data[off]) begin errors++; $display("FAIL bubble_data[%0d]: got %h want %h", off, data_arr, exp_data[off]); end
      checks++; if (act_ready !== (off < 4)) begin errors++; $display("FAIL bubble_ready[%0d]: got %b want %b", off, act_ready, (off < 4)); end
      checks++; if (done !== (off == 12)) begin errors++; $display("FAIL bubble_done[%0d]: got %b want %b", off, done, (off == 12)); end
      act_valid = (off < 4) ? vld[off] : 1'b0;
      act_data = (off < 4) ? vec[off] : 32'h0;
      tick();
    end
    act_valid = 1'b0; act_data = '0;
`ifdef FEEDER_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL stall_cnt: got %0d want 1", stall_cnt); end
`endif
  endtask

  task automatic test_num_vec_zero();
    start_job(16'd0);
    load_held();
    checks++; if (act_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_drain_entry: got rdy=%b busy=%b want 0 1", act_ready, busy); end
    for (int d = 0; d < 10; d++) begin
      checks++; if (data_arr !== 32'h0) begin errors++; $display("FAIL zero_data[%0d]: got %h want 0", d, data_arr); end
      checks++; if (done !== (d == 8) || busy !== (d < 8)) begin errors++; $display("FAIL zero_seq[%0d]: got done=%b busy=%b want %b %b", d, done, busy, (d == 8), (d < 8)); end
      start = (d == 2 || d == 8);
      num_vec = start ? 16'd7 : 16'd0;
      tick();
    end
    start = 1'b0; num_vec = '0;
    checks++; if (wt_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_start_ignored: got rdy=%b busy=%b want 0 0", wt_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_weight_and_skew();
    test_wt_toggle();
    test_bubble();
    test_num_vec_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
